// File: rtl/caravel_scan_pkg.sv
// Shared TAP types and constants for caravel_scan_tap.
// Holds the 16-state TAP enum, the IR opcodes and the IR capture value.
package caravel_scan_pkg;

  localparam int IR_W = 4;

  typedef enum logic [3:0] {
    TLR,
    RTI,
    SEL_DR,
    CAP_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPD_DR,
    SEL_IR,
    CAP_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPD_IR
  } tap_state_e;

  localparam logic [IR_W-1:0] OP_IDCODE  = 4'b0001;
  localparam logic [IR_W-1:0] OP_PRELOAD = 4'b0011;
  localparam logic [IR_W-1:0] OP_BYPASS  = 4'b1111;
  localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0101;

endpackage

// File: rtl/caravel_scan_tap_fsm.sv
// TAP state register and tms-driven next-state logic.
// Ports: clock, resetb, i_trst_n, i_tms in; o_state out.
module tap_fsm
  import caravel_scan_pkg::*;
(
  input  logic       clock,
  input  logic       resetb,
  input  logic       i_trst_n,
  input  logic       i_tms,
  output tap_state_e o_state
);

  tap_state_e r_state;
  tap_state_e w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      TLR:      w_next = i_tms ? TLR      : RTI;
      RTI:      w_next = i_tms ? SEL_DR   : RTI;
      SEL_DR:   w_next = i_tms ? SEL_IR   : CAP_DR;
      CAP_DR:   w_next = i_tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: w_next = i_tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: w_next = i_tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: w_next = i_tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: w_next = i_tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   w_next = i_tms ? SEL_DR   : RTI;
      SEL_IR:   w_next = i_tms ? TLR      : CAP_IR;
      CAP_IR:   w_next = i_tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: w_next = i_tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: w_next = i_tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: w_next = i_tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: w_next = i_tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   w_next = i_tms ? SEL_DR   : RTI;
      default:  w_next = TLR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetb || !i_trst_n) r_state <= TLR;
    else                      r_state <= w_next;
  end

  assign o_state = r_state;

endmodule

// File: rtl/caravel_scan_tap.sv
// TAP controller fronting the fault-injection scan chain.
// Ports: clock/resetb/tms/tdi/trst_n in, tdo/tdo_oe out, chain_cap in, chain_q out.
module caravel_scan_tap
  import caravel_scan_pkg::*;
#(
  parameter int          CHAIN_LEN  = 502,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic                 tms,
  input  logic                 tdi,
  input  logic                 trst_n,
  output logic                 tdo,
  output logic                 tdo_oe,
  input  logic [CHAIN_LEN-1:0] chain_cap,
  output logic [CHAIN_LEN-1:0] chain_q
);

  tap_state_e w_state;

  logic [IR_W-1:0]      r_ir;
  logic [IR_W-1:0]      r_ir_sr;
  logic [CHAIN_LEN-1:0] r_chain;
  logic [CHAIN_LEN-1:0] r_chain_q;
  logic [31:0]          r_id;
  logic                 r_byp;
  logic                 w_sel_chain;
  logic                 w_sel_id;
  logic                 w_tdo;

  tap_fsm u_fsm (
    .clock    (clock),
    .resetb   (resetb),
    .i_trst_n (trst_n),
    .i_tms    (tms),
    .o_state  (w_state)
  );

  assign w_sel_chain = (r_ir == OP_PRELOAD);
  assign w_sel_id    = (r_ir == OP_IDCODE);

  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_ir      <= OP_IDCODE;
      r_ir_sr   <= '0;
      r_chain   <= '0;
      r_chain_q <= '0;
      r_id      <= '0;
      r_byp     <= 1'b0;
    end else if (!trst_n) begin
      r_ir <= OP_IDCODE;
    end else begin
      case (w_state)
        TLR:      r_ir    <= OP_IDCODE;
        CAP_IR:   r_ir_sr <= IR_CAPTURE;
        SHIFT_IR: r_ir_sr <= {tdi, r_ir_sr[IR_W-1:1]};
        UPD_IR:   r_ir    <= r_ir_sr;
        CAP_DR: begin
          r_chain <= chain_cap;
          r_id    <= IDCODE_VAL;
          r_byp   <= 1'b0;
        end
        SHIFT_DR: begin
          if (w_sel_chain)
            r_chain <= {tdi, r_chain[CHAIN_LEN-1:1]};
          else if (w_sel_id)
            r_id <= {tdi, r_id[31:1]};
          else
            r_byp <= tdi;
        end
        UPD_DR: if (w_sel_chain) r_chain_q <= r_chain;
        default: ;
      endcase
    end
  end

  // tdo reflects the pre-edge bit so it is valid during the shift cycle
  always_comb begin
    w_tdo = 1'b0;
    if (w_state == SHIFT_IR)
      w_tdo = r_ir_sr[0];
    else if (w_state == SHIFT_DR)
      w_tdo = w_sel_chain ? r_chain[0] :
              w_sel_id    ? r_id[0]    : r_byp;
  end

  assign tdo     = w_tdo;
  assign tdo_oe  = (w_state == SHIFT_IR) || (w_state == SHIFT_DR);
  assign chain_q = r_chain_q;

endmodule

// File: tb/tb_caravel_scan_tap.sv
// Directed scoreboard bench for caravel_scan_tap.
// Drives tms/tdi at negedge and compares tdo against queued expectations.
module tb_caravel_scan_tap;
  import caravel_scan_pkg::*;

  localparam int N = 502;

  logic         clock = 1'b0;
  logic         resetb, tms, tdi, trst_n;
  logic         tdo, tdo_oe;
  logic [N-1:0] chain_cap, chain_q;
  logic [N-1:0] pat;
  logic [31:0]  idv = 32'h0000_0001;
  logic         s_tdo, s_oe;
  logic         sb[$];
  int           ncmp = 0;
  int           nerr = 0;

  caravel_scan_tap #(.CHAIN_LEN(N), .IDCODE_VAL(32'h0000_0001)) dut (
    .clock     (clock),
    .resetb    (resetb),
    .tms       (tms),
    .tdi       (tdi),
    .trst_n    (trst_n),
    .tdo       (tdo),
    .tdo_oe    (tdo_oe),
    .chain_cap (chain_cap),
    .chain_q   (chain_q)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [N-1:0] exp);
    ncmp++;
    assert (chain_q === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, chain_q, exp);
    end
  endtask

  task automatic step(input logic t, input logic d);
    tms = t;
    tdi = d;
    s_tdo = tdo;
    s_oe = tdo_oe;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic shift(input string tag, input logic t,
                       input logic d, input logic exp);
    logic e;
    sb.push_back(exp);
    step(t, d);
    e = sb.pop_front();
    chk(tag, s_tdo, e);
    chk({tag, "_oe"}, s_oe, 1'b1);
  endtask

  task automatic to_shift_dr();
    step(1, 0);
    step(0, 0);
    step(0, 0);
  endtask

  task automatic to_rti();
    step(1, 0);
    step(0, 0);
  endtask

  task automatic load_ir(input logic [3:0] op);
    logic [3:0] cap;
    cap = IR_CAPTURE;
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < 4; i++)
      shift("ir_cap", i == 3, op[i], cap[i]);
    to_rti();
  endtask

  task automatic read_id(input string tag);
    to_shift_dr();
    for (int i = 0; i < 32; i++)
      shift(tag, i == 31, 1'b0, idv[i]);
    to_rti();
  endtask

  initial begin
    logic [3:0] byp_in;
    logic [3:0] byp_out;
    byp_in  = 4'b1101;
    byp_out = 4'b1010;
    for (int i = 0; i < N; i++) begin
      chain_cap[i] = 1'($urandom);
      pat[i] = 1'($urandom);
    end
    resetb = 1'b0;
    trst_n = 1'b1;
    tms = 1'b1;
    tdi = 1'b0;
    @(negedge clock);
    step(1, 0);
    resetb = 1'b1;
    step(1, 0);

    chk("rst_tdo", tdo, 1'b0);
    chk("rst_oe", tdo_oe, 1'b0);
    chk_q("rst_chain_q", '0);
    step(0, 0);
    read_id("idcode");

    load_ir(OP_PRELOAD);

    to_shift_dr();
    for (int i = 0; i < N; i++)
      shift("chain_cap", 1'b0, pat[i], chain_cap[i]);
    for (int i = 0; i < N; i++)
      shift("chain_pat", i == N - 1, pat[i], pat[i]);
    to_rti();
    chk_q("preload_q", pat);

    load_ir(OP_BYPASS);
    to_shift_dr();
    for (int i = 0; i < 4; i++)
      shift("bypass", i == 3, byp_in[i], byp_out[i]);
    to_rti();
    chk_q("bypass_q", pat);

    load_ir(OP_PRELOAD);
    to_shift_dr();
    for (int i = 0; i < 3; i++)
      shift("pre_trst", 1'b0, 1'b0, chain_cap[i]);
    trst_n = 1'b0;
    step(0, 0);
    trst_n = 1'b1;
    chk("trst_oe", tdo_oe, 1'b0);
    chk_q("trst_q", pat);
    step(0, 0);
    read_id("trst_id");

    load_ir(OP_PRELOAD);
    to_shift_dr();
    shift("pre_tms5", 1'b0, 1'b0, chain_cap[0]);
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("tms5_oe", tdo_oe, 1'b0);
    step(0, 0);
    read_id("tms5_id");

    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    shift("pre_rst", 1'b0, 1'b1, 1'b1);
    resetb = 1'b0;
    step(0, 1);
    resetb = 1'b1;
    chk("rst2_tdo", tdo, 1'b0);
    chk("rst2_oe", tdo_oe, 1'b0);
    chk_q("rst2_q", '0);
    step(0, 0);
    read_id("rst2_id");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
